// File: rtl/alarm_pkg.sv
// alarm_pkg -- shared definitions for the alarm controller.
//   alarm_state_e : FSM state encoding (OFF, ARMED, RINGING, SNOOZE)
//   *_DEF         : default ring length, snooze length and snooze allowance
//   cnt_width()   : counter width for a down-counter loaded with n-1,
//                   never narrower than one bit
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_e;

  localparam int unsigned RING_SECS_DEF   = 60;
  localparam int unsigned SNOOZE_SECS_DEF = 300;
  localparam int unsigned MAX_SNOOZE_DEF  = 3;

  // A down-counter that starts at n-1 needs $clog2(n) bits; a degenerate
  // n of 0 or 1 would give a zero-width vector, so clamp to one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_rise_det.sv
// rise_det -- registers a level input and flags its rising edge.
//   clk   : second tick
//   rst_n : asynchronous active-low reset, clears the history register
//   d     : level input (snooze button)
//   pulse : high while d is 1 and was 0 at the previous edge
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  // Combinational so the FSM acts on the press at the very edge that
  // first samples it high.
  assign pulse = d & ~d_q;

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl -- alarm clock sequencer: arm, ring, snooze, auto-dismiss.
//   clk                : one-cycle-per-second tick
//   rst_n              : asynchronous active-low reset
//   alarm_on           : alarm enable switch (level, highest priority)
//   snooze             : snooze button (level, rising edge acted on)
//   tsec, tmin, thrs   : current time, binary
//   amin, ahrs         : alarm setting, binary
//   buzz               : high while ringing
//   snoozing           : high during a snooze interval
// Both outputs are decoded straight from the state register.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = RING_SECS_DEF,
  parameter int unsigned SNOOZE_SECS = SNOOZE_SECS_DEF,
  parameter int unsigned MAX_SNOOZE  = MAX_SNOOZE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alarm_on,
  input  logic       snooze,
  input  logic [6:0] tsec,
  input  logic [6:0] tmin,
  input  logic [6:0] thrs,
  input  logic [6:0] amin,
  input  logic [6:0] ahrs,
  output logic       buzz,
  output logic       snoozing
);

  localparam int unsigned RW = cnt_width(RING_SECS);
  localparam int unsigned WW = cnt_width(SNOOZE_SECS);
  localparam int unsigned SW = cnt_width(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] RING_LOAD   = RW'(RING_SECS - 1);
  localparam logic [WW-1:0] WAIT_LOAD   = WW'(SNOOZE_SECS - 1);
  localparam logic [SW-1:0] SNOOZE_LIM  = SW'(MAX_SNOOZE);

  alarm_state_e  state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;

  logic snz_pulse;
  logic match;

  rise_det u_snz_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (snooze),
    .pulse (snz_pulse)
  );

  // Alarm fires only on the exact second the minute rolls over.
  assign match = (thrs == ahrs) && (tmin == amin) && (tsec == 7'd0);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    wait_cnt_d = wait_cnt_q;
    snz_cnt_d  = snz_cnt_q;

    if (!alarm_on) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        // Arming edge deliberately skips the match check.
        ST_OFF: begin
          state_d = ST_ARMED;
        end

        ST_ARMED: begin
          if (match) begin
            state_d    = ST_RINGING;
            ring_cnt_d = RING_LOAD;
            snz_cnt_d  = '0;
          end
        end

        // A press outranks expiry of the ring window on the same edge.
        ST_RINGING: begin
          if (snz_pulse) begin
            if (snz_cnt_q < SNOOZE_LIM) begin
              state_d    = ST_SNOOZE;
              wait_cnt_d = WAIT_LOAD;
              snz_cnt_d  = snz_cnt_q + SW'(1);
            end else begin
              state_d = ST_ARMED;
            end
          end else if (ring_cnt_q == '0) begin
            state_d = ST_ARMED;
          end else begin
            ring_cnt_d = ring_cnt_q - RW'(1);
          end
        end

        // Presses are ignored here; the allowance is kept across the wait.
        ST_SNOOZE: begin
          if (wait_cnt_q == '0) begin
            state_d    = ST_RINGING;
            ring_cnt_d = RING_LOAD;
          end else begin
            wait_cnt_d = wait_cnt_q - WW'(1);
          end
        end

        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      ring_cnt_q <= '0;
      wait_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  assign buzz     = (state_q == ST_RINGING);
  assign snoozing = (state_q == ST_SNOOZE);

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl -- directed scenarios plus randomized episodes, every
// cycle compared against a seconds-based behavioural model of the alarm.
module tb_alarm_ctrl;

  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;
  localparam int DAY  = 86400;

  localparam int M_OFF   = 0;
  localparam int M_ARMED = 1;
  localparam int M_RING  = 2;
  localparam int M_SNZ   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alarm_on = 1'b0;
  logic       snooze = 1'b0;
  logic [6:0] tsec, tmin, thrs, amin, ahrs;
  logic       buzz, snoozing;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .RING_SECS   (RING),
    .SNOOZE_SECS (SNZ),
    .MAX_SNOOZE  (MAXS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alarm_on (alarm_on),
    .snooze   (snooze),
    .tsec     (tsec),
    .tmin     (tmin),
    .thrs     (thrs),
    .amin     (amin),
    .ahrs     (ahrs),
    .buzz     (buzz),
    .snoozing (snoozing)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Wall clock as seconds of the day; alarm as seconds of the day.
  int now_s;
  int alarm_s;

  // Reference model: mode plus "seconds of sound/silence still to go".
  int   m_mode;
  int   m_ring_left;
  int   m_snz_left;
  int   m_presses;
  logic m_prev_snz;

  int buzz_cycles;
  int snz_cycles;

  task automatic chk(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode      = M_OFF;
    m_ring_left = 0;
    m_snz_left  = 0;
    m_presses   = 0;
    m_prev_snz  = 1'b0;
  endtask

  task automatic model_edge();
    bit press;
    bit at_alarm;
    at_alarm   = (now_s == alarm_s);
    press      = snooze && !m_prev_snz;
    m_prev_snz = snooze;
    if (!alarm_on) begin
      m_mode = M_OFF;
    end else begin
      case (m_mode)
        M_OFF:   m_mode = M_ARMED;
        M_ARMED: if (at_alarm) begin
          m_mode      = M_RING;
          m_ring_left = RING;
          m_presses   = 0;
        end
        M_RING: begin
          if (press) begin
            if (m_presses < MAXS) begin
              m_mode     = M_SNZ;
              m_snz_left = SNZ;
              m_presses++;
            end else begin
              m_mode = M_ARMED;
            end
          end else begin
            m_ring_left--;
            if (m_ring_left == 0) m_mode = M_ARMED;
          end
        end
        default: begin
          m_snz_left--;
          if (m_snz_left == 0) begin
            m_mode      = M_RING;
            m_ring_left = RING;
          end
        end
      endcase
    end
  endtask

  task automatic drive_time();
    tsec = 7'(now_s % 60);
    tmin = 7'((now_s / 60) % 60);
    thrs = 7'((now_s / 3600) % 24);
  endtask

  task automatic set_alarm(input int h, input int m);
    ahrs    = 7'(h);
    amin    = 7'(m);
    alarm_s = h * 3600 + m * 60;
  endtask

  // One second: drive inputs, let the DUT take the edge, compare outputs.
  task automatic tick(input logic on, input logic snz);
    @(negedge clk);
    alarm_on = on;
    snooze   = snz;
    drive_time();
    @(posedge clk);
    model_edge();
    #1;
    chk("buzz", int'(buzz), int'(m_mode == M_RING));
    chk("snoozing", int'(snoozing), int'(m_mode == M_SNZ));
    if (buzz) buzz_cycles++;
    if (snoozing) snz_cycles++;
    now_s = (now_s + 1) % DAY;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_buzz", int'(buzz), 0);
    chk("async_rst_snoozing", int'(snoozing), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_buzz", int'(buzz), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Assumes the FSM is ARMED (or OFF, which the first tick arms).
  task automatic trigger();
    now_s = (alarm_s - 1 + DAY) % DAY;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
  endtask

  initial begin
    bit snz_lvl;
    bit on_lvl;
    int len;
    model_reset();
    set_alarm(7, 30);
    now_s = 7 * 3600 + 29 * 60;
    drive_time();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_buzz", int'(buzz), 0);
    chk("reset_snoozing", int'(snoozing), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arming edge at the match second must not ring.
    tick(1'b0, 1'b0);
    now_s = alarm_s;
    tick(1'b1, 1'b0);
    chk("arm_no_trigger", int'(buzz), 0);
    run(3);
    $display("arming edge at match second: buzz=%0b", buzz);

    // 07:29:59 -> 07:30:00 rings for exactly RING seconds.
    buzz_cycles = 0;
    snz_cycles  = 0;
    trigger();
    chk("ring_first_edge", int'(buzz), 1);
    run(RING + 10);
    chk("ring_len", buzz_cycles, RING);
    chk("ring_no_snooze", snz_cycles, 0);
    $display("plain ring: %0d buzz cycles", buzz_cycles);

    // Snooze press ten seconds into the ring.
    buzz_cycles = 0;
    snz_cycles  = 0;
    trigger();
    run(9);
    tick(1'b1, 1'b1);
    chk("snooze_enter", int'(snoozing), 1);
    run(SNZ + RING + 20);
    chk("snooze_len", snz_cycles, SNZ);
    chk("snooze_ring_total", buzz_cycles, 10 + RING);
    $display("single snooze: %0d silent, %0d buzz", snz_cycles, buzz_cycles);

    // Four presses: three snoozes, the fourth dismisses.
    snz_cycles = 0;
    trigger();
    for (int p = 0; p < 4; p++) begin
      run(2);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      len = 0;
      while (m_mode == M_SNZ && len < SNZ + 5) begin
        tick(1'b1, 1'b0);
        len++;
      end
      $display("press %0d: silence followed by %0d cycles", p + 1, len);
    end
    chk("fourth_press_buzz", int'(buzz), 0);
    chk("fourth_press_snoozing", int'(snoozing), 0);
    chk("three_silences", snz_cycles, 3 * SNZ);
    run(5);

    // Drop alarm_on while ringing, then while snoozing.
    trigger();
    run(4);
    tick(1'b0, 1'b0);
    chk("drop_ring", int'(buzz), 0);
    run(20);
    chk("reenable_quiet", int'(buzz), 0);
    trigger();
    tick(1'b1, 1'b1);
    run(5);
    tick(1'b0, 1'b0);
    chk("drop_snooze", int'(snoozing), 0);
    run(20);
    $display("alarm_on drop during ring and snooze done");

    // Reset mid-ring: immediate silence, ring again only at the next match.
    trigger();
    run(5);
    reset_pulse();
    buzz_cycles = 0;
    run(100);
    chk("post_rst_quiet", buzz_cycles, 0);
    trigger();
    chk("post_rst_ring", int'(buzz), 1);
    $display("reset mid-ring done");

    // Held snooze counts once; edge on the last ring second still snoozes.
    run(3);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    chk("held_once", m_presses, 1);
    run(SNZ + RING + 5);
    trigger();
    run(RING - 1);
    tick(1'b1, 1'b1);
    chk("snz_at_ring_end", int'(snoozing), 1);
    run(10);
    $display("held press and last-second press done");

    // Randomized episodes.
    for (int ep = 0; ep < 20; ep++) begin
      set_alarm(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
      now_s   = (alarm_s - int'($urandom_range(1, 5)) + DAY) % DAY;
      len     = int'($urandom_range(50, 800));
      snz_lvl = 1'b0;
      on_lvl  = 1'b1;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 39) == 0) snz_lvl = !snz_lvl;
        if ($urandom_range(0, 299) == 0) on_lvl = 1'b0;
        else if (!on_lvl && $urandom_range(0, 9) == 0) on_lvl = 1'b1;
        if ($urandom_range(0, 499) == 0) reset_pulse();
        tick(on_lvl, snz_lvl);
      end
      $display("episode %0d: alarm %0d:%0d, %0d seconds, presses %0d",
               ep, ahrs, amin, len, m_presses);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
